// File: rtl/cmd_uart_tx.sv
// cmd_uart_tx: serializes 32-bit command words into four UART 8N1 bytes,
// most significant byte first, LSB-first within each byte.
module cmd_uart_tx #(
    parameter int FREQ_MHZ = 25,
    parameter int BAUD     = 115200,
    parameter int DIV      = FREQ_MHZ * 1000000 / BAUD
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        cmd_axis_tvalid_i,
    output logic        cmd_axis_tready_o,
    input  logic [31:0] cmd_axis_tdata_i,
    output logic        tx_o,
    output logic        busy_o
);

    // A bit period shorter than two clocks cannot be represented.
    generate
        if (DIV < 2) begin : g_div_check
            $error("cmd_uart_tx: DIV must be at least 2");
        end
    endgenerate

    localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       r_byte_idx;
    logic [2:0]       r_bit_idx;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [31:0]      r_word;
    logic             r_tx;

    logic             w_ready;
    logic             w_accept;
    logic             w_bit_end;
    logic [7:0]       w_cur_byte;

    assign w_ready   = (r_state == S_IDLE) && !reset_i;
    assign w_accept  = cmd_axis_tvalid_i && w_ready;
    assign w_bit_end = (r_baud_cnt == CNT_LAST);

    assign cmd_axis_tready_o = w_ready;
    assign busy_o            = (r_state != S_IDLE);
    assign tx_o              = r_tx;

    // Byte on the line: byte 0 is the top byte of the latched word.
    always_comb begin
        w_cur_byte = r_word[31:24];
        case (r_byte_idx)
            2'd0:    w_cur_byte = r_word[31:24];
            2'd1:    w_cur_byte = r_word[23:16];
            2'd2:    w_cur_byte = r_word[15:8];
            default: w_cur_byte = r_word[7:0];
        endcase
    end

    // Baud counter: parked at 0 in IDLE, wraps on every bit boundary.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_baud_cnt <= '0;
        end else if (r_state == S_IDLE || w_bit_end) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    // Frame sequencer; the line level is registered one step ahead so that
    // tx_o changes on the same edge the state does.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_word     <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_accept) begin
                        r_word     <= cmd_axis_tdata_i;
                        r_byte_idx <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= S_START;
                        r_tx       <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_bit_idx <= '0;
                        r_tx      <= w_cur_byte[0];
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= w_cur_byte[r_bit_idx + 3'd1];
                        end
                    end
                end
                default: begin
                    if (w_bit_end) begin
                        if (r_byte_idx != 2'd3) begin
                            // Next byte's start bit abuts this stop bit.
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_tx       <= 1'b0;
                            r_state    <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
